// File: rtl/pixel_pkg.sv
// Shared constants for the scaler output stage.
// FIFO entry layout: {pixel data, eol, sof}.
package pixel_pkg;

   localparam int PIX_BYTE = 8;

   localparam int SOF_BIT  = 0;
   localparam int EOL_BIT  = 1;
   localparam int DATA_LSB = 2;

   function automatic int entry_width(input int channels);
      return PIX_BYTE * channels + DATA_LSB;
   endfunction

   function automatic int ctr_width(input int range_n);
      return (range_n > 1) ? $clog2(range_n) : 1;
   endfunction

endpackage

// File: rtl/pixel_stream_out_sync_fifo.sv
// First-word-fall-through FIFO; the head entry is visible whenever count != 0.
// A push into an empty FIFO becomes visible on the following cycle.
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_i) wptr_d = wptr_q + 1'b1;
      if (pop_i)  rptr_d = rptr_q + 1'b1;
      unique case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q];
   assign full_o  = (count_q == CNT_FULL);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/pixel_stream_out.sv
// Scaler output stage: packs channel bytes into pixels, buffers them and
// streams one frame in raster order with sof/eol markers.
module pixel_stream_out
   import pixel_pkg::*;
#(
   parameter int W_out   = 4,
   parameter int H_out   = 4,
   parameter int CHANNEL = 1,
   parameter int DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [PIX_BYTE-1:0]         in_data,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [PIX_BYTE*CHANNEL-1:0] m_data,
   output logic                        m_sof,
   output logic                        m_eol,
   output logic                        frame_done
);

   localparam int EW   = entry_width(CHANNEL);
   localparam int DW   = PIX_BYTE * CHANNEL;
   localparam int CHW  = ctr_width(CHANNEL);
   localparam int XW   = ctr_width(W_out);
   localparam int YW   = ctr_width(H_out);
   localparam int NPIX = W_out * H_out;
   localparam int OW   = $clog2(NPIX + 1);

   localparam logic [CHW-1:0] CH_LAST = CHW'(CHANNEL - 1);
   localparam logic [XW-1:0]  X_LAST  = XW'(W_out - 1);
   localparam logic [YW-1:0]  Y_LAST  = YW'(H_out - 1);
   localparam logic [OW-1:0]  O_LAST  = OW'(NPIX - 1);

   logic [CHW-1:0] ch_q, ch_d;
   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d;
   logic           closed_q, closed_d;
   logic [OW-1:0]  out_q, out_d;
   logic           done_q, done_d;

   logic [CHANNEL-1:0][PIX_BYTE-1:0] stage_q, stage_d;

   logic                   accept;
   logic                   push;
   logic                   pop;
   logic                   pix_sof;
   logic                   pix_eol;
   logic [EW-1:0]          fifo_wdata;
   logic [EW-1:0]          fifo_rdata;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;

   assign in_ready = !rst && !fifo_full && !closed_q;
   assign accept   = in_valid && in_ready;
   assign push     = accept && (ch_q == CH_LAST);
   assign pop      = m_valid && m_ready;

   assign pix_sof = (x_q == '0) && (y_q == '0);
   assign pix_eol = (x_q == X_LAST);

   // The last byte goes straight into the pushed word, not via staging.
   always_comb begin
      stage_d = stage_q;
      if (accept) stage_d[ch_q] = in_data;
   end

   always_comb begin
      fifo_wdata = '0;
      fifo_wdata[EW-1:DATA_LSB] = stage_d;
      fifo_wdata[SOF_BIT]       = pix_sof;
      fifo_wdata[EOL_BIT]       = pix_eol;
   end

   always_comb begin
      ch_d     = ch_q;
      x_d      = x_q;
      y_d      = y_q;
      closed_d = closed_q;
      out_d    = out_q;
      done_d   = done_q;
      if (accept) begin
         ch_d = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
      end
      if (push) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) closed_d = 1'b1;
            else               y_d = y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
      if (pop) begin
         out_d = out_q + 1'b1;
         if (out_q == O_LAST) done_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ch_q     <= '0;
         x_q      <= '0;
         y_q      <= '0;
         closed_q <= 1'b0;
         out_q    <= '0;
         done_q   <= 1'b0;
         stage_q  <= '0;
      end else begin
         ch_q     <= ch_d;
         x_q      <= x_d;
         y_q      <= y_d;
         closed_q <= closed_d;
         out_q    <= out_d;
         done_q   <= done_d;
         stage_q  <= stage_d;
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (fifo_wdata),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign m_valid    = (fifo_count != '0) && !done_q;
   assign m_data     = m_valid ? fifo_rdata[EW-1:DATA_LSB] : DW'(0);
   assign m_sof      = m_valid && fifo_rdata[SOF_BIT];
   assign m_eol      = m_valid && fifo_rdata[EOL_BIT];
   assign frame_done = done_q;

   a_empty_count: assert property (@(posedge clk) disable iff (rst)
      fifo_empty == (fifo_count == '0));

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && fifo_full));

endmodule

// File: tb/tb_pixel_stream_out.sv
// Self-checking bench: three DUT configurations (1, 3 and 2 channels)
// checked against a raster/packing model kept in the bench.
module tb_pixel_stream_out;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic        a_rst, a_iv, a_ir, a_mv, a_mr, a_sof, a_eol, a_fd;
   logic [7:0]  a_id, a_md;
   logic        b_rst, b_iv, b_ir, b_mv, b_mr, b_sof, b_eol, b_fd;
   logic [7:0]  b_id;
   logic [23:0] b_md;
   logic        c_rst, c_iv, c_ir, c_mv, c_mr, c_sof, c_eol, c_fd;
   logic [7:0]  c_id;
   logic [15:0] c_md;

   pixel_stream_out #(.W_out(4), .H_out(4), .CHANNEL(1), .DEPTH(4)) u_a (
      .clk(clk), .rst(a_rst), .in_valid(a_iv), .in_ready(a_ir),
      .in_data(a_id), .m_valid(a_mv), .m_ready(a_mr), .m_data(a_md),
      .m_sof(a_sof), .m_eol(a_eol), .frame_done(a_fd));

   pixel_stream_out #(.W_out(4), .H_out(4), .CHANNEL(3), .DEPTH(4)) u_b (
      .clk(clk), .rst(b_rst), .in_valid(b_iv), .in_ready(b_ir),
      .in_data(b_id), .m_valid(b_mv), .m_ready(b_mr), .m_data(b_md),
      .m_sof(b_sof), .m_eol(b_eol), .frame_done(b_fd));

   pixel_stream_out #(.W_out(4), .H_out(4), .CHANNEL(2), .DEPTH(4)) u_c (
      .clk(clk), .rst(c_rst), .in_valid(c_iv), .in_ready(c_ir),
      .in_data(c_id), .m_valid(c_mv), .m_ready(c_mr), .m_data(c_md),
      .m_sof(c_sof), .m_eol(c_eol), .frame_done(c_fd));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_a();
      a_rst = 1'b1; a_iv = 1'b0; a_mr = 1'b0;
      tick();
      a_rst = 1'b0;
   endtask

   task automatic test_reset();
      a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
      tick(); tick();
      @(negedge clk);
      n_cmp++;
      if (a_ir !== 1'b0) begin
         n_err++; $display("FAIL reset_in_ready_low: got %b want 0", a_ir);
      end
      tick();
      a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({a_mv, a_sof, a_eol, a_fd} !== 4'b0000) begin
         n_err++; $display("FAIL reset_flags: got mv/sof/eol/fd=%b want 0000",
                           {a_mv, a_sof, a_eol, a_fd});
      end
      n_cmp++;
      if (a_md !== 8'h00) begin
         n_err++; $display("FAIL reset_m_data: got %h want 00", a_md);
      end
      n_cmp++;
      if ({a_ir, b_ir, c_ir} !== 3'b111) begin
         n_err++; $display("FAIL reset_in_ready_high: got %b want 111",
                           {a_ir, b_ir, c_ir});
      end
      tick();
   endtask

   // Streams one full frame through the 1-channel DUT and checks every pop.
   task automatic run_a(input bit rand_data, input int ready_pct,
                        input string tag);
      logic [7:0] exp_q[$];
      logic [7:0] held = 8'h00;
      bit was_held = 1'b0;
      int sent = 0, got = 0, post = 0, cyc = 0;
      reset_a();
      for (int i = 0; i < 16; i++)
         exp_q.push_back(rand_data ? 8'($urandom) : 8'(i));
      while (cyc < 800 && post < 3) begin
         a_iv = 1'b1;
         a_id = (sent < 16) ? exp_q[sent] : 8'hEE;
         a_mr = ($urandom_range(0, 99) < ready_pct);
         @(negedge clk);
         if (sent == 16) begin
            n_cmp++;
            if (a_ir !== 1'b0) begin
               n_err++; $display("FAIL %s closed_in_ready: got %b want 0", tag, a_ir);
            end
         end
         n_cmp++;
         if (a_fd !== (got == 16)) begin
            n_err++; $display("FAIL %s frame_done: got %b want %b", tag, a_fd, got == 16);
         end
         if (got == 16) begin
            n_cmp++;
            if (a_mv !== 1'b0) begin
               n_err++; $display("FAIL %s extra_pixel: m_valid %b want 0", tag, a_mv);
            end
         end
         if (was_held) begin
            n_cmp++;
            if (a_mv !== 1'b1 || a_md !== held) begin
               n_err++; $display("FAIL %s stall_stable: got mv=%b data=%h want 1 %h",
                                 tag, a_mv, a_md, held);
            end
         end
         if (a_iv && a_ir) sent++;
         if (a_mv && a_mr && got < 16) begin
            n_cmp++;
            if (a_md !== exp_q[got] || a_sof !== (got == 0) ||
                a_eol !== (got % 4 == 3)) begin
               n_err++;
               $display("FAIL %s pixel%0d: got data=%h sof=%b eol=%b want %h %b %b",
                        tag, got, a_md, a_sof, a_eol, exp_q[got], got == 0,
                        got % 4 == 3);
            end
            got++;
         end
         was_held = a_mv && !a_mr;
         held = a_md;
         if (got == 16) post++;
         cyc++;
         tick();
      end
      a_iv = 1'b0; a_mr = 1'b0;
      n_cmp++;
      if (got != 16) begin
         n_err++; $display("FAIL %s timeout: popped %0d want 16", tag, got);
      end
   endtask

   task automatic test_basic_raster();
      run_a(1'b0, 100, "basic");
   endtask

   task automatic test_close_after_last();
      run_a(1'b1, 60, "close");
   endtask

   task automatic test_random_stall();
      run_a(1'b1, 30, "stall");
   endtask

   task automatic test_backpressure();
      int k = 0, cyc = 0;
      reset_a();
      while (k < 4 && cyc < 50) begin
         a_iv = 1'b1; a_id = 8'(8'h40 + k);
         @(negedge clk);
         if (a_iv && a_ir) k++;
         cyc++;
         tick();
      end
      a_iv = 1'b1; a_id = 8'h44;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (a_ir !== 1'b0 || a_mv !== 1'b1 || a_md !== 8'h40) begin
            n_err++; $display("FAIL bp_full: got ir=%b mv=%b data=%h want 0 1 40",
                              a_ir, a_mv, a_md);
         end
         tick();
      end
      a_mr = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (a_ir !== 1'b0 || a_mv !== 1'b1 || a_md !== 8'h40) begin
         n_err++; $display("FAIL bp_pop: got ir=%b mv=%b data=%h want 0 1 40",
                           a_ir, a_mv, a_md);
      end
      tick();
      a_mr = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (a_ir !== 1'b1 || a_md !== 8'h41) begin
         n_err++; $display("FAIL bp_release: got ir=%b data=%h want 1 41", a_ir, a_md);
      end
      tick();
      a_iv = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (a_ir !== 1'b0) begin
         n_err++; $display("FAIL bp_refill: got ir=%b want 0", a_ir);
      end
      tick();
   endtask

   task automatic test_pack();
      logic [7:0]  bytes[12];
      logic [23:0] pix[4];
      b_rst = 1'b1; b_iv = 1'b0; b_mr = 1'b0;
      tick();
      b_rst = 1'b0;
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
      for (int i = 3; i < 12; i++) bytes[i] = 8'($urandom);
      for (int p = 0; p < 4; p++)
         pix[p] = {bytes[3*p+2], bytes[3*p+1], bytes[3*p]};
      for (int p = 0; p < 4; p++) begin
         for (int c = 0; c < 3; c++) begin
            b_iv = 1'b1; b_id = bytes[3*p+c];
            @(negedge clk);
            n_cmp++;
            if (b_ir !== 1'b1) begin
               n_err++; $display("FAIL pack_in_ready p%0d c%0d: got %b want 1", p, c, b_ir);
            end
            if (p == 0) begin
               n_cmp++;
               if (b_mv !== 1'b0) begin
                  n_err++; $display("FAIL pack_early_valid c%0d: got %b want 0", c, b_mv);
               end
            end
            if (p == 1 && c == 0) begin
               n_cmp++;
               if (b_mv !== 1'b1 || b_md !== 24'h332211) begin
                  n_err++; $display("FAIL pack_latency: got mv=%b data=%h want 1 332211",
                                    b_mv, b_md);
               end
            end
            tick();
         end
      end
      b_iv = 1'b0; b_mr = 1'b1;
      for (int p = 0; p < 4; p++) begin
         @(negedge clk);
         n_cmp++;
         if (b_mv !== 1'b1 || b_md !== pix[p] || b_sof !== (p == 0) ||
             b_eol !== (p == 3)) begin
            n_err++;
            $display("FAIL pack_pixel%0d: got mv=%b data=%h sof=%b eol=%b want 1 %h %b %b",
                     p, b_mv, b_md, b_sof, b_eol, pix[p], p == 0, p == 3);
         end
         tick();
      end
      b_mr = 1'b0;
   endtask

   task automatic test_mid_reset();
      int nb = 0, cyc = 0;
      c_rst = 1'b1; c_iv = 1'b0; c_mr = 1'b0;
      tick();
      c_rst = 1'b0;
      while (nb < 13 && cyc < 100) begin
         c_iv = 1'b1; c_id = 8'($urandom); c_mr = (nb < 8);
         @(negedge clk);
         if (c_iv && c_ir) nb++;
         cyc++;
         tick();
      end
      c_iv = 1'b0; c_mr = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (nb != 13 || c_mv !== 1'b1) begin
         n_err++; $display("FAIL mid_prefill: got bytes=%0d mv=%b want 13 1", nb, c_mv);
      end
      tick();
      c_rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (c_ir !== 1'b0) begin
         n_err++; $display("FAIL mid_rst_in_ready: got %b want 0", c_ir);
      end
      tick();
      c_rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (c_mv !== 1'b0 || c_md !== 16'h0 || c_fd !== 1'b0 || c_ir !== 1'b1) begin
         n_err++; $display("FAIL mid_after_rst: got mv=%b data=%h fd=%b ir=%b want 0 0000 0 1",
                           c_mv, c_md, c_fd, c_ir);
      end
      tick();
      c_iv = 1'b1; c_id = 8'hA1;
      @(negedge clk);
      tick();
      c_id = 8'hB2;
      @(negedge clk);
      tick();
      c_iv = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (c_mv !== 1'b1 || c_md !== 16'hB2A1 || c_sof !== 1'b1 || c_eol !== 1'b0) begin
         n_err++; $display("FAIL mid_first_pixel: got mv=%b data=%h sof=%b eol=%b want 1 b2a1 1 0",
                           c_mv, c_md, c_sof, c_eol);
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      a_rst = 1'b1; a_iv = 1'b0; a_id = 8'h00; a_mr = 1'b0;
      b_rst = 1'b1; b_iv = 1'b0; b_id = 8'h00; b_mr = 1'b0;
      c_rst = 1'b1; c_iv = 1'b0; c_id = 8'h00; c_mr = 1'b0;
      test_reset();
      test_basic_raster();
      test_backpressure();
      test_close_after_last();
      test_pack();
      test_mid_reset();
      test_random_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pixel_stream_out.md
# pixel_stream_out

Downstream output stage of the scaler. It accepts the interpolated bytes one channel at a time (value, channel 0 first), packs CHANNEL bytes into one pixel word and buffers it in a small FIFO. It then emits the output frame in raster order on a valid/ready stream with start-of-frame and end-of-line markers. Backpressure reaches the scaler through `in_ready`. The block handles one frame per reset.

## Interface

Parameters:
- W_out, 4, output image width in pixels
- H_out, 4, output image height in pixels
- CHANNEL, 1, bytes per pixel (1..4)
- DEPTH, 4, FIFO depth in pixels; power of two, ≥2

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- in_valid  in  1  scaler presents a byte
- in_ready  out  1  block accepts the byte this cycle
- in_data  in  8  interpolated channel byte
- m_valid  out  1  pixel word available
- m_ready  in  1  consumer takes the pixel
- m_data  out  8*CHANNEL  pixel; channel c in bits [8c+7:8c]
- m_sof  out  1  head pixel is (0,0)
- m_eol  out  1  head pixel is the last in its row
- frame_done  out  1  all W_out*H_out pixels delivered; sticky

## Operation

- **Input handshake:** a byte transfers when in_valid && in_ready.
- **in_ready:** equals !fifo_full && !in_closed, combinational from registers only. It never depends on m_ready.
- **Channel packing:** a channel counter `ch` runs 0..CHANNEL-1. Each accepted byte is written to staging lane `ch`.
- **Push:** on the byte with ch == CHANNEL-1, the full word is pushed together with flags:
  - sof = (x_in==0 && y_in==0)
  - eol = (x_in==W_out-1)
- **Input counters:** x_in and y_in advance in raster order on each push. On the push of pixel (W_out-1, H_out-1), in_closed is set and in_ready drops.
- **FIFO:** first-word-fall-through, with count of width $clog2(DEPTH)+1.
  - Push when count==DEPTH cannot happen (in_ready is low).
  - Push and pop in the same cycle leaves count unchanged and is legal at count 0 only if the word was already present. With count 0, a same-cycle push is not visible until the next cycle.
  - Pointers wrap modulo DEPTH.
- **Output:** m_valid = (count != 0). m_data, m_sof and m_eol come from the head entry and are forced to 0 when m_valid is low.
- **Pop:** occurs on m_valid && m_ready. Holding m_valid with m_ready low keeps the head word stable.
- **Frame completion:** an output pixel counter increments on each pop. The pop of pixel W_out*H_out-1 sets frame_done on the next edge, and it stays high until rst. After frame_done, m_valid is 0.
- **Reset:** rst at any cycle, including mid-frame, clears ch, x_in, y_in, in_closed, FIFO pointers and count, the output counter and frame_done. Any partially packed pixel and any buffered pixels are discarded.
- **Reset values:**
  - m_valid=0, m_data=0, m_sof=0, m_eol=0, frame_done=0.
  - in_ready=1 in the first cycle after rst is released. in_ready reads 0 while rst is high.

## Timing

- **Latency:** last channel byte accepted at edge N → m_valid=1 after edge N (visible cycle N+1), provided the FIFO was empty.
- **Throughput:** one byte per cycle in, one pixel per cycle out. Sustained rate is one pixel per CHANNEL cycles, limited by the input.
- **in_ready timing:** in_ready falls in the cycle after the push that fills the FIFO. It rises in the cycle after a pop frees a slot, so there is no combinational m_ready→in_ready path.
- **frame_done:** high in the cycle after the final pop handshake.

## Structure

- **Shared package** (pixel_pkg):
  - PIX_BYTE = 8
  - flag bit positions (SOF, EOL) in the FIFO entry
  - a pixel-entry width function of CHANNEL
- **Sub-module** sync_fifo (WIDTH = 8*CHANNEL+2, DEPTH): FWFT, with full/empty/count outputs.
- **Top level:** packing, raster counters and frame logic stay in pixel_stream_out.

## Test plan

- **Basic raster, W_out=4, H_out=4, CHANNEL=1, m_ready=1:** feed bytes 0x00..0x0F back to back → m_data 0x00..0x0F in order; m_sof only on 0x00; m_eol on 0x03, 0x07, 0x0B, 0x0F; frame_done high one cycle after the 16th pop.
- **Packing, CHANNEL=3:** bytes 0x11, 0x22, 0x33 → one pixel m_data=0x332211, m_valid rising the cycle after 0x33 is accepted.
- **Backpressure, DEPTH=4, m_ready=0:** after 4 pixels are pushed, in_ready=0 and a fifth in_valid is held. Raise m_ready for 1 cycle → one pop; in_ready=1 the following cycle.
- **Close after last pixel:** after pixel (3,3) is accepted, in_ready stays 0 with in_valid=1 and no extra pixel appears. Drain remaining pixels → frame_done=1 and stays 1.
- **Mid-frame reset:** after 6 pixels and 1 stray byte (CHANNEL=2), assert rst for 1 cycle → m_valid=0, frame_done=0, count 0. The next byte lands in channel 0, and the next pixel has m_sof=1.
- **Random m_ready stall:** 30% random m_ready with continuous input → output sequence is identical to input order; no word is duplicated or lost; m_data stays stable while m_valid && !m_ready.
